// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Simon game sequencer.
// Adds one random button per round, plays the sequence back with fixed
// on/off timing, then checks the player's presses one by one. Ends in a
// sticky LOSE (wrong button) or WIN (MAX_LEN rounds completed).
// Optional build macro SIMON_TIMEOUT_EN: when defined, TIMEOUT_TICKS cycles
// without a new press while waiting for the player also ends in LOSE.
module simon_seq_engine #(
  parameter int BTN_W         = 2,
  parameter int MAX_LEN       = 16,
  parameter int LEN_W         = 5,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] rand_in,
  input  logic [BTN_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LEN_W-1:0] round_len,
  output logic             game_over,
  output logic             win
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int T_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int T_MAX  = (T_MAX0 > TIMEOUT_TICKS) ? T_MAX0 : TIMEOUT_TICKS;
  localparam int TICK_W = $clog2(T_MAX + 1);

  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TICK_W-1:0] TO_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_LOSE,
    S_WIN
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [BTN_W-1:0]  num_q;
  logic              prev_pressed;
  logic              mem_we;
  logic              rise, fall, last_step;
  logic [BTN_W-1:0]  mem [MAX_LEN];

  assign rise      = player_pressed & ~prev_pressed;
  assign fall      = ~player_pressed & prev_pressed;
  // idx points at the final element of the current sequence
  assign last_step = (LEN_W'(idx) == (len_q - LEN_W'(1)));

  // Sequence storage: one new entry per round, never cleared
  always_ff @(posedge clk) begin
    if (mem_we) mem[len_q[IDX_W-1:0]] <= rand_in;
  end

  // State, counters and edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_ADD;
      idx          <= '0;
      tick         <= '0;
      len_q        <= '0;
      prev_pressed <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      tick         <= tick_nxt;
      len_q        <= len_nxt;
      prev_pressed <= player_pressed;
    end
  end

  // Last shown button, so simon_num holds steady between lit phases
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   num_q <= '0;
    else if (state == S_SHOW_ON) num_q <= mem[idx];
  end

  // Next-state and counter updates
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tick_nxt  = tick;
    len_nxt   = len_q;
    mem_we    = 1'b0;
    case (state)
      S_ADD: begin
        mem_we    = 1'b1;
        len_nxt   = len_q + LEN_W'(1);
        idx_nxt   = '0;
        tick_nxt  = '0;
        state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick == ON_LAST) begin
          tick_nxt  = '0;
          state_nxt = S_SHOW_OFF;
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (tick == OFF_LAST) begin
          tick_nxt = '0;
          if (last_step) begin
            idx_nxt   = '0;
            state_nxt = S_WAIT_PRESS;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_SHOW_ON;
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      S_WAIT_PRESS: begin
        // only a fresh rising edge counts; a button held on entry is ignored
        if (rise) begin
          tick_nxt  = '0;
          state_nxt = (player_num == mem[idx]) ? S_WAIT_RELEASE : S_LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tick == TO_LAST) begin
          state_nxt = S_LOSE;
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
`endif
      end
      S_WAIT_RELEASE: begin
        if (fall) begin
          if (!last_step) begin
            idx_nxt   = idx + IDX_W'(1);
            tick_nxt  = '0;
            state_nxt = S_WAIT_PRESS;
          end else if (len_q == LEN_MAX) begin
            state_nxt = S_WIN;
          end else begin
            state_nxt = S_ADD;
          end
        end
      end
      S_LOSE:  state_nxt = S_LOSE;
      S_WIN:   state_nxt = S_WIN;
      default: state_nxt = S_ADD;
    endcase
  end

  // Outputs decode straight from state so reset takes effect immediately
  assign simon_turn    = (state == S_ADD) || (state == S_SHOW_ON) || (state == S_SHOW_OFF);
  assign simon_pressed = (state == S_SHOW_ON);
  assign simon_num     = simon_pressed ? mem[idx] : num_q;
  assign round_len     = len_q;
  assign game_over     = (state == S_LOSE);
  assign win           = (state == S_WIN);

endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine: small game model checked every cycle plus
// directed games (lose, win, async reset, idle/timeout).
module tb_simon_seq_engine;

  localparam int BTN_W = 2;
  localparam int LEN_W = 3;
  localparam int MAXL  = 4;
  localparam int ON    = 3;
  localparam int OFF   = 2;
  localparam int TO    = 10;
  localparam int PER   = ON + OFF;

  localparam int PH_ADD  = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_WP   = 2;
  localparam int PH_WR   = 3;
  localparam int PH_LOSE = 4;
  localparam int PH_WIN  = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [BTN_W-1:0] rand_in = '0;
  logic [BTN_W-1:0] player_num = '0;
  logic             player_pressed = 1'b0;
  logic             simon_turn;
  logic [BTN_W-1:0] simon_num;
  logic             simon_pressed;
  logic [LEN_W-1:0] round_len;
  logic             game_over;
  logic             win;

  int n_assert = 0;
  int n_fail   = 0;

  logic [BTN_W-1:0] golden [4];

  simon_seq_engine #(
    .BTN_W(BTN_W), .MAX_LEN(MAXL), .LEN_W(LEN_W),
    .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .rand_in(rand_in),
    .player_num(player_num), .player_pressed(player_pressed),
    .simon_turn(simon_turn), .simon_num(simon_num),
    .simon_pressed(simon_pressed), .round_len(round_len),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int m_phase = PH_ADD;
  int seq_q[$];
  int m_t = 0;
  int m_pos = 0;
  int m_idle = 0;
  int m_last = 0;
  bit m_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = PH_ADD; seq_q.delete();
        m_t = 0; m_pos = 0; m_idle = 0; m_last = 0; m_prev = 1'b0;
      end else begin
        bit rise_m, fall_m;
        rise_m = player_pressed && !m_prev;
        fall_m = !player_pressed && m_prev;
        case (m_phase)
          PH_ADD: begin
            seq_q.push_back(int'(rand_in));
            m_t = 0;
            m_phase = PH_PLAY;
          end
          PH_PLAY: begin
            m_t++;
            if (m_t == seq_q.size() * PER) begin
              m_phase = PH_WP; m_pos = 0; m_idle = 0;
            end
          end
          PH_WP: begin
            if (rise_m) begin
              m_idle = 0;
              m_phase = (int'(player_num) == seq_q[m_pos]) ? PH_WR : PH_LOSE;
            end else begin
              m_idle++;
`ifdef SIMON_TIMEOUT_EN
              if (m_idle == TO) m_phase = PH_LOSE;
`endif
            end
          end
          PH_WR: begin
            if (fall_m) begin
              if (m_pos < seq_q.size() - 1) begin
                m_pos++; m_idle = 0; m_phase = PH_WP;
              end else if (seq_q.size() == MAXL) m_phase = PH_WIN;
              else m_phase = PH_ADD;
            end
          end
          default: ;
        endcase
        m_prev = player_pressed;
        if (m_phase == PH_PLAY && (m_t % PER) < ON) m_last = seq_q[m_t / PER];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("simon_turn",    32'(simon_turn),    32'(m_phase == PH_ADD || m_phase == PH_PLAY));
      chk("simon_pressed", 32'(simon_pressed), 32'(m_phase == PH_PLAY && (m_t % PER) < ON));
      chk("simon_num",     32'(simon_num),     m_last);
      chk("round_len",     32'(round_len),     seq_q.size());
      chk("game_over",     32'(game_over),     32'(m_phase == PH_LOSE));
      chk("win",           32'(win),           32'(m_phase == PH_WIN));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_press(input logic [BTN_W-1:0] n);
    player_num = n; player_pressed = 1'b1; cyc(1);
    player_pressed = 1'b0; cyc(1);
  endtask

  task automatic wait_turn();
    int n;
    n = 0;
    while (simon_turn && n < 200) begin cyc(1); n++; end
    chk("wait_turn_bound", 32'(simon_turn), 0);
  endtask

  // Replay the first n golden buttons; nxt is the button added next round
  task automatic play_round(input int n, input logic [BTN_W-1:0] nxt);
    wait_turn();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) rand_in = nxt;
      do_press(golden[i]);
    end
  endtask

  // ---------------- directed games ----------------
  initial begin
    golden[0] = 2'd2; golden[1] = 2'd1; golden[2] = 2'd3; golden[3] = 2'd0;

    // Game A: round 1 timing, then lose on round 2
    reset = 1'b1; rand_in = 2'd2;
    cyc(3);
    chk("rst_turn", 32'(simon_turn), 1);
    chk("rst_len",  32'(round_len), 0);
    chk("rst_lit",  32'(simon_pressed), 0);
    chk("rst_num",  32'(simon_num), 0);
    reset = 1'b0;
    cyc(1);
    chk("r1_len",   32'(round_len), 1);
    chk("r1_lit_a", 32'(simon_pressed), 1);
    chk("r1_num_a", 32'(simon_num), 2);
    cyc(2);
    chk("r1_lit_c", 32'(simon_pressed), 1);
    cyc(1);
    chk("r1_dark_a", 32'(simon_pressed), 0);
    chk("r1_num_hold", 32'(simon_num), 2);
    cyc(1);
    chk("r1_dark_b_turn", 32'(simon_turn), 1);
    cyc(1);
    chk("r1_player_turn", 32'(simon_turn), 0);
    rand_in = 2'd1;
    do_press(2'd2);
    cyc(1);
    chk("r2_len", 32'(round_len), 2);
    chk("r2_first_num", 32'(simon_num), 2);
    wait_turn();
    do_press(2'd2);
    player_num = 2'd3; player_pressed = 1'b1;
    chk("lose_pre", 32'(game_over), 0);
    cyc(1);
    chk("lose_now", 32'(game_over), 1);
    player_pressed = 1'b0; cyc(1);
    do_press(2'd0);
    do_press(2'd1);
    chk("lose_sticky", 32'(game_over), 1);
    chk("lose_turn", 32'(simon_turn), 0);
    chk("lose_win",  32'(win), 0);

    // Game B: held button across hand-over, then win
    reset = 1'b1; rand_in = 2'd2;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    player_num = 2'd0; player_pressed = 1'b1; cyc(1);
    player_pressed = 1'b0; cyc(1);
    player_num = 2'd2; player_pressed = 1'b1;
    wait_turn();
    cyc(3);
    chk("held_len", 32'(round_len), 1);
    player_pressed = 1'b0;
    cyc(1);
    chk("held_release_turn", 32'(simon_turn), 0);
    chk("held_release_go", 32'(game_over), 0);
    rand_in = 2'd1;
    do_press(2'd2);
    play_round(2, 2'd3);
    play_round(3, 2'd0);
    play_round(4, 2'd0);
    chk("win_flag", 32'(win), 1);
    chk("win_len",  32'(round_len), 4);
    chk("win_go",   32'(game_over), 0);
    chk("win_turn", 32'(simon_turn), 0);
    do_press(2'd3);
    chk("win_sticky", 32'(win), 1);

    // Game C: async reset during round-3 playback, then idle behaviour
    reset = 1'b1; rand_in = 2'd2;
    cyc(2);
    reset = 1'b0;
    play_round(1, 2'd1);
    play_round(2, 2'd3);
    cyc(3);
    chk("r3_len", 32'(round_len), 3);
    chk("r3_lit", 32'(simon_pressed), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_turn", 32'(simon_turn), 1);
    chk("arst_lit",  32'(simon_pressed), 0);
    chk("arst_num",  32'(simon_num), 0);
    chk("arst_len",  32'(round_len), 0);
    chk("arst_go",   32'(game_over), 0);
    chk("arst_win",  32'(win), 0);
    cyc(1);
    reset = 1'b0; rand_in = 2'd2;
    cyc(1);
    chk("restart_len", 32'(round_len), 1);
    wait_turn();
`ifdef SIMON_TIMEOUT_EN
    cyc(TO - 1);
    chk("timeout_pre", 32'(game_over), 0);
    cyc(1);
    chk("timeout_hit", 32'(game_over), 1);
`else
    cyc(1000);
    chk("idle_no_lose", 32'(game_over), 0);
    chk("idle_turn",    32'(simon_turn), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
